// File: rtl/viterbi_pkg.sv
// viterbi_pkg: code parameters and encoder FSM state shared by the encoder and Viterbi decoder
package viterbi_pkg;
    localparam int K = 3;
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;
    localparam int TAIL_LEN = K - 1;
    typedef enum logic {RUN, FLUSH} enc_state_t;
endpackage

// File: rtl/conv_sym_gen.sv
// conv_sym_gen: combinational generator parity for one input bit against the shift register
module conv_sym_gen #(
    parameter int K = viterbi_pkg::K,
    parameter logic [K-1:0] G0 = viterbi_pkg::G0,
    parameter logic [K-1:0] G1 = viterbi_pkg::G1
) (
    input  logic         b,
    input  logic [K-2:0] sr,
    output logic [1:0]   sym
);
    logic [K-1:0] v;
    always_comb begin
        v = {b, sr};
        sym = {^(v & G0), ^(v & G1)};
    end
endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 streaming convolutional encoder with automatic zero-tail termination
module conv_encoder
    import viterbi_pkg::*;
#(
    parameter int K = viterbi_pkg::K,
    parameter logic [K-1:0] G0 = viterbi_pkg::G0,
    parameter logic [K-1:0] G1 = viterbi_pkg::G1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [1:0]       out_sym,
    output logic             out_last,
    input  logic             out_ready,
    output logic [CNT_W-1:0] sym_count,
    output logic             frame_done
);
    localparam int TW = $clog2(K);
    enc_state_t state, state_nx;
    logic [K-2:0] sr;
    logic [TW-1:0] tail_cnt;
    logic slot_free, load, b, tail_end;
    logic [1:0] sym;
    logic [CNT_W-1:0] cnt_base;

    conv_sym_gen #(.K(K), .G0(G0), .G1(G1)) u_sym_gen (
        .b(b),
        .sr(sr),
        .sym(sym)
    );

    always_comb begin
        slot_free = !out_valid || out_ready;
        in_ready = !rst && state == RUN && slot_free;
        load = state == RUN ? in_valid && in_ready : slot_free;
        b = state == RUN ? in_bit : 1'b0;
        tail_end = state == FLUSH && tail_cnt == TW'(K - 2);
        frame_done = out_valid && out_ready && out_last;
        cnt_base = frame_done ? '0 : sym_count;
        state_nx = state;
        if (load && state == RUN && in_last)
            state_nx = FLUSH;
        if (load && tail_end)
            state_nx = RUN;
    end

    // The single output slot refills in the same cycle it drains, giving full throughput
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            sr <= '0;
            tail_cnt <= '0;
            sym_count <= '0;
            out_valid <= 1'b0;
            out_sym <= 2'b00;
            out_last <= 1'b0;
        end else begin
            state <= state_nx;
            sym_count <= load && cnt_base != '1 ? cnt_base + 1'b1 : cnt_base;
            if (load) begin
                sr <= {b, sr[K-2:1]};
                out_valid <= 1'b1;
                out_sym <= sym;
                out_last <= tail_end;
                tail_cnt <= state == RUN ? '0 : tail_cnt + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: directed scenario tests for conv_encoder with hand-computed symbol streams
module tb_conv_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, out_last, frame_done;
    logic [1:0] out_sym;
    logic [15:0] sym_count;

    int checks = 0;
    int errors = 0;
    bit toggle_mode = 0;
    int cyc_n = 0;
    int ncyc = 0;
    logic [1:0] sym_q[$];
    logic last_q[$];
    int fd_cnt, acc_cnt, stall_bad, stall_cyc, max_cnt, first_t, last_t;
    logic prev_stall = 1'b0;
    logic [1:0] prev_sym;
    logic prev_last;

    conv_encoder dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_bit(in_bit),
        .in_last(in_last),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_sym(out_sym),
        .out_last(out_last),
        .out_ready(out_ready),
        .sym_count(sym_count),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: time %0t", $time);
        $fatal(1, "timeout");
    end

    // Observe handshakes mid-cycle; inputs change just after posedge
    always @(negedge clk) begin
        ncyc++;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sym_q.size() == 0)
                    first_t = ncyc;
                last_t = ncyc;
                sym_q.push_back(out_sym);
                last_q.push_back(out_last);
            end
            if (frame_done)
                fd_cnt++;
            if (in_valid && in_ready)
                acc_cnt++;
            if (int'(sym_count) > max_cnt)
                max_cnt = int'(sym_count);
            if (out_valid && !out_ready) begin
                stall_cyc++;
                if (in_ready)
                    stall_bad++;
            end
            if (prev_stall && (!out_valid || out_sym !== prev_sym || out_last !== prev_last))
                stall_bad++;
            prev_stall = out_valid && !out_ready;
            prev_sym = out_sym;
            prev_last = out_last;
        end
    end

    task automatic clear();
        sym_q.delete();
        last_q.delete();
        fd_cnt = 0;
        acc_cnt = 0;
        stall_bad = 0;
        stall_cyc = 0;
        max_cnt = 0;
        first_t = 0;
        last_t = 0;
        prev_stall = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc_n++;
        out_ready = toggle_mode ? (cyc_n % 3 == 0) : 1'b1;
    endtask

    task automatic send(input logic [7:0] bits, input logic [7:0] lasts, input int n);
        int i = 0;
        int g = 0;
        while (i < n && g < 200) begin
            in_valid = 1'b1;
            in_bit = bits[i];
            in_last = lasts[i];
            @(negedge clk);
            if (in_ready)
                i++;
            cycle();
            g++;
        end
        in_valid = 1'b0;
        in_bit = 1'b0;
        in_last = 1'b0;
        checks++;
        if (i != n) begin
            errors++;
            $display("FAIL send_accept: accepted %0d want %0d", i, n);
        end
    endtask

    task automatic drain(input int n);
        int g = 0;
        @(negedge clk);
        #1;
        while (sym_q.size() < n && g < 100) begin
            cycle();
            @(negedge clk);
            #1;
            g++;
        end
        cycle();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_sym, out_last, frame_done, sym_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b s=%b l=%b fd=%b cnt=%0d want all 0", out_valid, out_sym, out_last, frame_done, sym_count);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [11:0] e = 12'b11_10_00_01_01_11;
        logic [5:0] el = 6'b000001;
        clear();
        send(8'b0000_1101, 8'b0000_1000, 4);
        drain(6);
        checks++;
        if (sym_q.size() != 6) begin
            errors++;
            $display("FAIL basic_len: got %0d want 6", sym_q.size());
        end
        for (int i = 0; i < 6 && i < sym_q.size(); i++) begin
            checks++;
            if (sym_q[i] !== e[11-2*i -: 2] || last_q[i] !== el[5-i]) begin
                errors++;
                $display("FAIL basic_sym%0d: got %b/%b want %b/%b", i, sym_q[i], last_q[i], e[11-2*i -: 2], el[5-i]);
            end
        end
        checks++;
        if (fd_cnt != 1) begin
            errors++;
            $display("FAIL basic_frame_done: got %0d pulses want 1", fd_cnt);
        end
        checks++;
        if (max_cnt != 6) begin
            errors++;
            $display("FAIL basic_sym_count_peak: got %0d want 6", max_cnt);
        end
        checks++;
        if (sym_count !== 16'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_clear: got cnt=%0d v=%b want 0 0", sym_count, out_valid);
        end
    endtask

    task automatic test_single();
        logic [5:0] e = 6'b00_00_00;
        logic [2:0] el = 3'b001;
        clear();
        send(8'b0, 8'b1, 1);
        drain(3);
        checks++;
        if (sym_q.size() != 3) begin
            errors++;
            $display("FAIL single_len: got %0d want 3", sym_q.size());
        end
        for (int i = 0; i < 3 && i < sym_q.size(); i++) begin
            checks++;
            if (sym_q[i] !== e[5-2*i -: 2] || last_q[i] !== el[2-i]) begin
                errors++;
                $display("FAIL single_sym%0d: got %b/%b want %b/%b", i, sym_q[i], last_q[i], e[5-2*i -: 2], el[2-i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [11:0] e = 12'b11_10_00_01_01_11;
        logic [5:0] el = 6'b000001;
        clear();
        toggle_mode = 1;
        send(8'b0000_1101, 8'b0000_1000, 4);
        drain(6);
        toggle_mode = 0;
        out_ready = 1'b1;
        checks++;
        if (sym_q.size() != 6) begin
            errors++;
            $display("FAIL stall_len: got %0d want 6", sym_q.size());
        end
        for (int i = 0; i < 6 && i < sym_q.size(); i++) begin
            checks++;
            if (sym_q[i] !== e[11-2*i -: 2] || last_q[i] !== el[5-i]) begin
                errors++;
                $display("FAIL stall_sym%0d: got %b/%b want %b/%b", i, sym_q[i], last_q[i], e[11-2*i -: 2], el[5-i]);
            end
        end
        checks++;
        if (stall_cyc == 0 || stall_bad != 0) begin
            errors++;
            $display("FAIL stall_hold: got %0d violations in %0d stalls want 0 in >0", stall_bad, stall_cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e = 16'b11_01_01_11_00_11_10_11;
        logic [7:0] el = 8'b0001_0001;
        clear();
        send(8'b0000_1011, 8'b0000_1010, 4);
        drain(8);
        checks++;
        if (sym_q.size() != 8) begin
            errors++;
            $display("FAIL b2b_len: got %0d want 8", sym_q.size());
        end
        for (int i = 0; i < 8 && i < sym_q.size(); i++) begin
            checks++;
            if (sym_q[i] !== e[15-2*i -: 2] || last_q[i] !== el[7-i]) begin
                errors++;
                $display("FAIL b2b_sym%0d: got %b/%b want %b/%b", i, sym_q[i], last_q[i], e[15-2*i -: 2], el[7-i]);
            end
        end
        checks++;
        if (last_t - first_t != 7 || fd_cnt != 2) begin
            errors++;
            $display("FAIL b2b_bubbles: got span %0d fd %0d want 7 2", last_t - first_t, fd_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] e = 12'b11_10_00_01_01_11;
        clear();
        send(8'b0000_1101, 8'b0000_1000, 4);
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_sym !== 2'b01 || sym_count !== 16'd5) begin
            errors++;
            $display("FAIL midreset_pre: got v=%b s=%b cnt=%0d want 1 01 5", out_valid, out_sym, sym_count);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_sym, out_last, frame_done, in_ready, sym_count} !== '0) begin
            errors++;
            $display("FAIL midreset_async: got v=%b s=%b l=%b fd=%b rdy=%b cnt=%0d want all 0", out_valid, out_sym, out_last, frame_done, in_ready, sym_count);
        end
        cycle();
        rst = 1'b0;
        clear();
        send(8'b0000_1101, 8'b0000_1000, 4);
        drain(6);
        checks++;
        if (sym_q.size() != 6) begin
            errors++;
            $display("FAIL midreset_len: got %0d want 6", sym_q.size());
        end
        for (int i = 0; i < 6 && i < sym_q.size(); i++) begin
            checks++;
            if (sym_q[i] !== e[11-2*i -: 2]) begin
                errors++;
                $display("FAIL midreset_sym%0d: got %b want %b", i, sym_q[i], e[11-2*i -: 2]);
            end
        end
    endtask

    task automatic test_hold_valid();
        logic [13:0] e = 14'b00_11_10_11_11_10_11;
        logic [6:0] el = 7'b0001_001;
        clear();
        send(8'b0000_0110, 8'b0000_0110, 3);
        drain(7);
        checks++;
        if (acc_cnt != 3) begin
            errors++;
            $display("FAIL hold_accepts: got %0d want 3", acc_cnt);
        end
        checks++;
        if (sym_q.size() != 7) begin
            errors++;
            $display("FAIL hold_len: got %0d want 7", sym_q.size());
        end
        for (int i = 0; i < 7 && i < sym_q.size(); i++) begin
            checks++;
            if (sym_q[i] !== e[13-2*i -: 2] || last_q[i] !== el[6-i]) begin
                errors++;
                $display("FAIL hold_sym%0d: got %b/%b want %b/%b", i, sym_q[i], last_q[i], e[13-2*i -: 2], el[6-i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_hold_valid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
